div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage, serving MIPS DIV and DIVU. It is the responder to the hazard unit's divide stall: the decoder's is_div drives `start`, and `ready` is fed back as div_ready. The hazard unit holds the E stage, with operands stable, until `ready` pulses. Exception flushes reach the divider through `annul`, which aborts an in-flight division.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// ============================================================================
// Module      : div_unit_if
// Description : Operand/result bundle between the E stage and the divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface div_unit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : 32-cycle restoring divider for MIPS DIV/DIVU, {rem, quo} out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module div_unit (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   dif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_qneg;
    logic        r_rneg;
    logic [5:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_ready;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_rem_final;
    logic [31:0] w_quo_final;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_a_neg     = dif.signed_div & dif.a[31];
    assign w_b_neg     = dif.signed_div & dif.b[31];
    assign w_a_abs     = w_a_neg ? (~dif.a + 32'd1) : dif.a;
    assign w_b_abs     = w_b_neg ? (~dif.b + 32'd1) : dif.b;

    assign w_shift     = {r_rem, r_quo[31]};
    assign w_diff      = w_shift - {1'b0, r_div};
    assign w_rem_next  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_next  = {r_quo[30:0], ~w_diff[32]};
    assign w_quo_final = r_qneg ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_final = r_rneg ? (~w_rem_next + 32'd1) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= 6'd0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dif.start && !dif.annul) begin
                        if (dif.b == 32'd0) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_rem   <= 32'd0;
                            r_quo   <= w_a_abs;
                            r_div   <= w_b_abs;
                            r_qneg  <= w_a_neg ^ w_b_neg;
                            r_rneg  <= w_a_neg;
                            r_cnt   <= 6'd0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_ZERO: begin
                    if (dif.annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= 64'd0;
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_BUSY: begin
                    if (dif.annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_result <= {w_rem_final, w_quo_final};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // start here belongs to the completing instruction.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dif.result = r_result;
    assign dif.ready  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit against an arithmetic model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_unit_if dif ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating division on magnitudes; quotient sign a^b, remainder sign a.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint unsigned ua, ub, q, r;
        logic [31:0] qq, rr;
        logic na, nb;
        if (b == 32'd0) return 64'd0;
        na = s && a[31];
        nb = s && b[31];
        ua = na ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        ub = nb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        q  = ua / ub;
        r  = ua % ub;
        qq = (na ^ nb) ? 32'(64'h1_0000_0000 - q) : q[31:0];
        rr = na ? 32'(64'h1_0000_0000 - r) : r[31:0];
        return {rr, qq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int lat, output logic after);
        dif.a          = a;
        dif.b          = b;
        dif.signed_div = s;
        dif.start      = 1'b1;
        lat            = -1;
        res            = 64'd0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (dif.ready === 1'b1) begin
                lat = k;
                res = dif.result;
                break;
            end
        end
        dif.start = 1'b0;
        tick();
        after = dif.ready;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        dif.a          = 32'd0;
        dif.b          = 32'd0;
        dif.signed_div = 1'b0;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        tick();
        tick();
        checks++;
        if (dif.result !== 64'd0) begin
            failures++;
            $display("FAIL reset_result got=%h want=%h", dif.result, 64'd0);
        end
        checks++;
        if (dif.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b want=0", dif.ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dif.ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_ready got=%b want=0", dif.ready);
        end
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        logic after;
        do_div(32'd100, 32'd7, 1'b0, res, lat, after);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL divu_latency got=%0d want=33", lat);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_result got=%h want=%h", res, {32'd2, 32'd14});
        end
        checks++;
        if (after !== 1'b0) begin
            failures++;
            $display("FAIL ready_width got=%b want=0", after);
        end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat;
        logic after;
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, after);
        checks++;
        if (lat !== 33 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            failures++;
            $display("FAIL div_neg got=%h lat=%0d want=%h lat=33", res, lat,
                     {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, res, lat, after);
        checks++;
        if (lat !== 33 || res !== {32'd1, 32'h7FFF_FFFC}) begin
            failures++;
            $display("FAIL divu_big got=%h lat=%0d want=%h lat=33", res, lat,
                     {32'd1, 32'h7FFF_FFFC});
        end
    endtask

    task automatic test_overflow_zero();
        logic [63:0] res;
        int lat;
        logic after;
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, after);
        checks++;
        if (lat !== 33 || res !== {32'd0, 32'h8000_0000}) begin
            failures++;
            $display("FAIL div_overflow got=%h lat=%0d want=%h lat=33", res, lat,
                     {32'd0, 32'h8000_0000});
        end
        do_div(32'd5, 32'd0, 1'b1, res, lat, after);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL div_zero_latency got=%0d want=2", lat);
        end
        checks++;
        if (res !== 64'd0) begin
            failures++;
            $display("FAIL div_zero_result got=%h want=0", res);
        end
    endtask

    task automatic test_annul();
        logic [63:0] res, prev;
        int lat;
        logic after, saw;
        do_div(32'd9, 32'd2, 1'b0, prev, lat, after);
        dif.a          = 32'd1000;
        dif.b          = 32'd3;
        dif.signed_div = 1'b1;
        dif.start      = 1'b1;
        saw            = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (dif.ready === 1'b1) saw = 1'b1;
        end
        dif.annul = 1'b1;
        dif.start = 1'b0;
        tick();
        dif.annul = 1'b0;
        if (dif.ready === 1'b1) saw = 1'b1;
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL annul_no_ready got=%b want=0", saw);
        end
        checks++;
        if (dif.result !== {32'd1, 32'd4}) begin
            failures++;
            $display("FAIL annul_result_hold got=%h want=%h", dif.result, {32'd1, 32'd4});
        end
        tick();
        do_div(32'd1000, 32'd3, 1'b1, res, lat, after);
        checks++;
        if (lat !== 33 || res !== {32'd1, 32'd333}) begin
            failures++;
            $display("FAIL annul_restart got=%h lat=%0d want=%h lat=33", res, lat,
                     {32'd1, 32'd333});
        end
    endtask

    task automatic test_back_to_back();
        int n, c1, c2;
        logic [63:0] r1, r2;
        n  = 0;
        c1 = -1;
        c2 = -1;
        r1 = 64'd0;
        r2 = 64'd0;
        dif.a          = 32'd9;
        dif.b          = 32'd2;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            tick();
            if (dif.ready === 1'b1) begin
                n++;
                if (n == 1) begin
                    c1    = k;
                    r1    = dif.result;
                    dif.a = 32'd20;
                    dif.b = 32'd6;
                end else if (n == 2) begin
                    c2        = k;
                    r2        = dif.result;
                    dif.start = 1'b0;
                end
            end
        end
        dif.start = 1'b0;
        checks++;
        if (n !== 2 || c1 !== 33 || c2 !== 67) begin
            failures++;
            $display("FAIL b2b_timing got=n%0d c%0d,%0d want=n2 c33,67", n, c1, c2);
        end
        checks++;
        if (r1 !== {32'd1, 32'd4} || r2 !== {32'd2, 32'd3}) begin
            failures++;
            $display("FAIL b2b_results got=%h,%h want=%h,%h", r1, r2,
                     {32'd1, 32'd4}, {32'd2, 32'd3});
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        logic after, saw;
        dif.a          = 32'd1000;
        dif.b          = 32'd7;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        rst       = 1'b1;
        dif.start = 1'b0;
        #1;
        checks++;
        if (dif.result !== 64'd0 || dif.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b want=0/0", dif.result, dif.ready);
        end
        tick();
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (dif.ready === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_ready got=%b want=0", saw);
        end
        do_div(32'd1000, 32'd7, 1'b0, res, lat, after);
        checks++;
        if (lat !== 33 || res !== {32'd6, 32'd142}) begin
            failures++;
            $display("FAIL reset_mid_restart got=%h lat=%0d want=%h lat=33", res, lat,
                     {32'd6, 32'd142});
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [31:0] a, b;
        logic s, after;
        int lat, want_lat, sel;
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            s   = 1'($urandom_range(0, 1));
            exp      = model(a, b, s);
            want_lat = (b == 32'd0) ? 2 : 33;
            do_div(a, b, s, res, lat, after);
            checks++;
            if (res !== exp || lat !== want_lat || after !== 1'b0) begin
                failures++;
                $display("FAIL random a=%h b=%h s=%b got=%h lat=%0d want=%h lat=%0d",
                         a, b, s, res, lat, exp, want_lat);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
